qword_mem_responder: RTL and testbench
======================================

Name: qword_mem_responder

Overview:
- Memory-side responder for the 128-bit qword bus driven by the data and instruction caches.
- Accepts one qword read or write request at a time.
- Serialises each request into four 32-bit beats on a synchronous single-port word SRAM.
- Returns a one-cycle completion pulse; read data is presented with that pulse.

Parameters:
- BUS_ADDRESS_WIDTH, default 20: byte address width of the bus. The qword address is bits [BUS_ADDRESS_WIDTH-1:4].
- WAIT_STATES, default 0: idle cycles inserted before the first SRAM beat, used to model slow memory. Legal range 0..15.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- bus_addr_i  in  BUS_ADDRESS_WIDTH-4  qword address, bits [BUS_ADDRESS_WIDTH-1:4].
- bus_data_i  in  128  write data. Word k occupies [32k+31:32k].
- bus_valid_i  in  1  request. The initiator holds it, together with address, data and write enable, until it sees the completion pulse.
- bus_we_i  in  1  1 = write qword, 0 = read qword.
- bus_data_o  out  128  read data, valid while bus_valid_o=1.
- bus_valid_o  out  1  completion pulse, exactly one cycle.
- mem_addr_o  out  BUS_ADDRESS_WIDTH-2  SRAM word address = {latched qword addr, beat[1:0]}.
- mem_data_o  out  32  SRAM write data.
- mem_en_o  out  1  SRAM access enable.
- mem_we_o  out  1  SRAM write enable; asserted only together with mem_en_o.
- mem_data_i  in  32  SRAM read data, arriving 1 cycle after the enabled read.

Behaviour:
- Reset (rst_ni=0 at a posedge):
  - state=IDLE, beat=0, wait counter=0.
  - bus_valid_o=0, bus_data_o=0, mem_en_o=0, mem_we_o=0.
  - A transfer in progress is abandoned. No ack is issued and no further SRAM beats occur.
- States: IDLE, WAIT, XFER, DRAIN, ACK, RELEASE.
- IDLE:
  - On bus_valid_i=1, latch bus_addr_i, bus_we_i and bus_data_i.
  - Clear beat. Load the wait counter with WAIT_STATES.
  - Next state: WAIT if WAIT_STATES>0, else XFER.
- WAIT: decrement the wait counter; go to XFER when it reaches 1.
- XFER:
  - mem_en_o=1, mem_addr_o={addr, beat}, mem_we_o=latched we, mem_data_o=latched word[beat].
  - beat increments each cycle, via an increment instance with DATA_WIDTH=2. Carry marks beat 3.
  - Reads: while beat>0, capture mem_data_i into read buffer word[beat-1].
  - On beat 3: a write goes to ACK; a read goes to DRAIN.
- DRAIN: mem_en_o=0; capture mem_data_i into word[3]; go to ACK.
- ACK:
  - bus_valid_o=1.
  - For reads, bus_data_o = the assembled buffer. For writes, bus_data_o holds its previous value.
  - Go to RELEASE.
- RELEASE: stay until bus_valid_i=0, then go to IDLE. This prevents a still-high request from the ack cycle being re-accepted.
- Latency, with the request first seen at edge T and W=WAIT_STATES:
  - Write: ack high in cycle T+W+5.
  - Read: ack high in cycle T+W+6.
  - Back-to-back minimum gap: the request must be low for at least one cycle after the ack.
- Stability: bus_addr_i, bus_data_i and bus_we_i are sampled only in IDLE. Changes on them mid-transfer have no effect.
- Outputs are decoded from registered state only; there is no combinational path from bus inputs to bus_valid_o.

Decomposition:
- Shared package (bus_pkg):
  - BUS_DATA_WIDTH_SHIFT=4, BUS_DATA_WIDTH=128, WORDS_PER_QWORD=4.
  - State encoding for this block.
  - Common to the caches and this block.
- Reuse the existing increment module for the beat counter.
- Natural sub-module: qword_word_buffer. It is a 4x32 register with a write-by-index port and a 128-bit parallel load and read, used for both the write lanes and the read assembly.

Test Plan:
- Write: W=0, bus_addr_i=0x00012, bus_data_i=0x44444444_33333333_22222222_11111111, we=1 -> SRAM word addresses 0x48..0x4B receive 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles; ack is a single-cycle pulse at T+5.
- Read back the same address -> bus_data_o=0x44444444_33333333_22222222_11111111 while bus_valid_o=1 at T+6; mem_we_o stays 0 throughout.
- WAIT_STATES=3 read -> no mem_en_o for 3 cycles after acceptance; ack at T+9.
- Request held high for 2 cycles after the ack -> no second transfer and no mem_en_o until the request drops and is raised again.
- rst_ni=0 asserted during XFER beat 1 -> mem_en_o=0 on the next cycle, no ack, state IDLE; a following read of 0x00012 returns correct data.
- Alternating write(0x00000, all 0xA5) and read(0x00001) with a 1-cycle request gap -> each gets exactly one ack; data is not corrupted across addresses.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the 128-bit qword bus used by the caches and the
// memory-side responder.
package bus_pkg;

  localparam int BUS_DATA_WIDTH_SHIFT = 4;
  localparam int BUS_DATA_WIDTH       = 128;
  localparam int WORDS_PER_QWORD      = 4;
  localparam int WORD_WIDTH           = BUS_DATA_WIDTH / WORDS_PER_QWORD;
  localparam int BEAT_WIDTH           = $clog2(WORDS_PER_QWORD);

  typedef logic [WORD_WIDTH-1:0]                      word_t;
  typedef logic [WORDS_PER_QWORD-1:0][WORD_WIDTH-1:0] qword_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_DRAIN,
    ST_ACK,
    ST_RELEASE
  } resp_state_e;

endpackage

// File: rtl/increment.sv
// Generic incrementer: data_o = data_i + 1, carry_o set when data_i is all ones.
module increment #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  carry_o
);

  assign {carry_o, data_o} = {1'b0, data_i} + (DATA_WIDTH + 1)'(1);

endmodule

// File: rtl/qword_word_buffer.sv
// 4x32 word register with a 128-bit parallel load and a write-by-index port;
// the parallel load wins when both are requested.
module qword_word_buffer
  import bus_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_i,
  input  logic [BUS_DATA_WIDTH-1:0] load_data_i,
  input  logic                      wr_en_i,
  input  logic [BEAT_WIDTH-1:0]     wr_idx_i,
  input  logic [WORD_WIDTH-1:0]     wr_data_i,
  output logic [BUS_DATA_WIDTH-1:0] data_o
);

  qword_t words_q;

  // NOTE: this storage is reset even though it is plain data, because it can
  // feed a bus output whose reset value must be zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      words_q <= '0;
    end else if (load_i) begin
      words_q <= load_data_i;
    end else if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign data_o = words_q;

endmodule

// File: rtl/qword_mem_responder.sv
// Memory-side responder: serialises one qword read/write into four 32-bit
// beats on a single-port word SRAM and returns a one-cycle completion pulse.
module qword_mem_responder
  import bus_pkg::*;
#(
  parameter int BUS_ADDRESS_WIDTH = 20,
  parameter int WAIT_STATES       = 0   // legal range 0..15
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] bus_addr_i,
  input  logic [BUS_DATA_WIDTH-1:0]                     bus_data_i,
  input  logic                                          bus_valid_i,
  input  logic                                          bus_we_i,
  output logic [BUS_DATA_WIDTH-1:0]                     bus_data_o,
  output logic                                          bus_valid_o,
  output logic [BUS_ADDRESS_WIDTH-3:0]                  mem_addr_o,
  output logic [WORD_WIDTH-1:0]                         mem_data_o,
  output logic                                          mem_en_o,
  output logic                                          mem_we_o,
  input  logic [WORD_WIDTH-1:0]                         mem_data_i
);

  localparam int         QADDR_W   = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  resp_state_e           state_q, state_d;
  logic [BEAT_WIDTH-1:0] beat_q, beat_d, beat_inc;
  logic                  beat_carry;
  logic [3:0]            wait_q, wait_d;
  logic [QADDR_W-1:0]    addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  wr_load;
  logic                  rd_wr_en;
  logic [BEAT_WIDTH-1:0] rd_wr_idx;
  qword_t                wr_words;
  qword_t                rd_words;

  increment #(.DATA_WIDTH(BEAT_WIDTH)) u_beat_inc (
    .data_i  (beat_q),
    .data_o  (beat_inc),
    .carry_o (beat_carry)
  );

  // Write lanes, loaded from the bus when a request is accepted.
  qword_word_buffer u_wr_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (wr_load),
    .load_data_i (bus_data_i),
    .wr_en_i     (1'b0),
    .wr_idx_i    ('0),
    .wr_data_i   ('0),
    .data_o      (wr_words)
  );

  // Read assembly; untouched by writes so bus_data_o keeps its last read value.
  qword_word_buffer u_rd_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (1'b0),
    .load_data_i ('0),
    .wr_en_i     (rd_wr_en),
    .wr_idx_i    (rd_wr_idx),
    .wr_data_i   (mem_data_i),
    .data_o      (rd_words)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case
  // statement leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wr_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_valid_i) begin
          addr_d  = bus_addr_i;
          we_d    = bus_we_i;
          wr_load = 1'b1;
          beat_d  = '0;
          wait_d  = WAIT_INIT;
          state_d = (WAIT_INIT != 4'd0) ? ST_WAIT : ST_XFER;
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = ST_XFER;
      end
      ST_XFER: begin
        beat_d = beat_inc;
        if (beat_carry) state_d = we_q ? ST_ACK : ST_DRAIN;
      end
      ST_DRAIN:   state_d = ST_ACK;
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (!bus_valid_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Read data lags its beat by one cycle, so beat n lands in word n-1 and the
  // last word is picked up in DRAIN.
  always_comb begin
    bus_valid_o = (state_q == ST_ACK);
    mem_en_o    = (state_q == ST_XFER);
    mem_we_o    = (state_q == ST_XFER) && we_q;
    mem_addr_o  = {addr_q, beat_q};
    mem_data_o  = (state_q == ST_XFER) ? wr_words[beat_q] : '0;
    rd_wr_en    = ((state_q == ST_XFER) && !we_q && (beat_q != '0))
                || (state_q == ST_DRAIN);
    rd_wr_idx   = (state_q == ST_DRAIN) ? BEAT_WIDTH'(WORDS_PER_QWORD - 1)
                                        : beat_q - BEAT_WIDTH'(1);
  end

  assign bus_data_o = rd_words;

endmodule

// File: tb/tb_qword_mem_responder.sv
// Bench for qword_mem_responder: a zero-wait and a three-wait-state instance,
// each backed by a word SRAM model, checked against a qword-level memory model.
module tb_qword_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  bus_addr  [2];
  logic [127:0] bus_data  [2];
  logic         bus_valid [2];
  logic         bus_we    [2];
  logic [127:0] rdata_o   [2];
  logic         ack       [2];
  logic [17:0]  mem_addr  [2];
  logic [31:0]  mem_wdata [2];
  logic         mem_en    [2];
  logic         mem_we    [2];
  logic [31:0]  mem_rdata [2];

  int total = 0;
  int bad   = 0;
  int wst [2] = '{0, 3};

  always #5 clk = ~clk;

  qword_mem_responder #(.BUS_ADDRESS_WIDTH(20), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .bus_addr_i(bus_addr[0]), .bus_data_i(bus_data[0]),
    .bus_valid_i(bus_valid[0]), .bus_we_i(bus_we[0]),
    .bus_data_o(rdata_o[0]), .bus_valid_o(ack[0]),
    .mem_addr_o(mem_addr[0]), .mem_data_o(mem_wdata[0]),
    .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_data_i(mem_rdata[0])
  );

  qword_mem_responder #(.BUS_ADDRESS_WIDTH(20), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .bus_addr_i(bus_addr[1]), .bus_data_i(bus_data[1]),
    .bus_valid_i(bus_valid[1]), .bus_we_i(bus_we[1]),
    .bus_data_o(rdata_o[1]), .bus_valid_o(ack[1]),
    .mem_addr_o(mem_addr[1]), .mem_data_o(mem_wdata[1]),
    .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_data_i(mem_rdata[1])
  );

  // Word SRAM models, one per instance; read data appears one cycle late.
  logic [31:0] sram [logic [18:0]];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mem_en[g]) begin
        if (mem_we[g]) sram[{1'(g), mem_addr[g]}] = mem_wdata[g];
        else mem_rdata[g] <= sram.exists({1'(g), mem_addr[g]}) ?
                             sram[{1'(g), mem_addr[g]}] : 32'h0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One bus transaction on instance d, checking beats, latency, data and the
  // single-cycle ack; optionally holds the request high after the ack.
  task automatic run_txn(input int d, input logic we, input logic [15:0] addr,
                         input logic [127:0] wdata, input logic [127:0] exp_rdata,
                         input int exp_lat, input int hold, input bit scramble);
    int n = 0;
    int beats = 0;
    int lat = -1;
    @(negedge clk);
    bus_addr[d] = addr; bus_data[d] = wdata; bus_we[d] = we; bus_valid[d] = 1'b1;
    @(posedge clk);
    while (lat < 0 && n < 40) begin
      @(negedge clk);
      n++;
      check("we_without_en", mem_we[d] & ~mem_en[d], 0);
      if (mem_en[d]) begin
        check("beat_cycle", n, wst[d] + 1 + beats);
        check("mem_addr", mem_addr[d], {addr, 2'(beats)});
        check("mem_we", mem_we[d], we);
        if (we) check("mem_wdata", mem_wdata[d], wdata[32*beats +: 32]);
        beats++;
      end
      if (scramble && n == 1) begin
        bus_addr[d] = 16'($urandom);
        bus_data[d] = {$urandom, $urandom, $urandom, $urandom};
        bus_we[d]   = ~we;
      end
      if (ack[d]) begin
        lat = n;
        check("ack_rdata", rdata_o[d], exp_rdata);
      end
    end
    check("ack_latency", lat, exp_lat);
    check("beat_count", beats, 4);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      check("ack_after", ack[d], 0);
      check("en_after", mem_en[d], 0);
    end
    bus_valid[d] = 1'b0;
  endtask

  // Qword-level reference model for instance 0.
  logic [127:0] ref_mem [logic [15:0]];
  logic [127:0] last_rd;

  task automatic txn0(input logic we, input logic [15:0] addr, input logic [127:0] wdata,
                      input int hold, input bit scramble);
    logic [127:0] exp;
    exp = we ? last_rd : (ref_mem.exists(addr) ? ref_mem[addr] : 128'h0);
    run_txn(0, we, addr, wdata, exp, we ? 5 : 6, hold, scramble);
    if (we) ref_mem[addr] = wdata;
    else last_rd = exp;
  endtask

  typedef struct {
    logic         we;
    logic [15:0]  addr;
    logic [127:0] data;
    logic [127:0] exp_rdata;
    int           exp_lat;
  } vec_t;

  localparam logic [127:0] QA = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] QP = {4{32'hA5A5A5A5}};
  localparam logic [127:0] QB = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] QC = 128'h0f0f0f0f_f0f0f0f0_00000000_ffffffff;

  initial begin
    vec_t vecs [10];
    vecs[0] = '{1'b1, 16'h0012, QA, 128'h0, 5};
    vecs[1] = '{1'b0, 16'h0012, 128'h0, QA, 6};
    vecs[2] = '{1'b1, 16'h0000, QP, QA, 5};
    vecs[3] = '{1'b0, 16'h0001, 128'h0, 128'h0, 6};
    vecs[4] = '{1'b0, 16'h0000, 128'h0, QP, 6};
    vecs[5] = '{1'b1, 16'h0001, QB, QP, 5};
    vecs[6] = '{1'b0, 16'h0001, 128'h0, QB, 6};
    vecs[7] = '{1'b0, 16'h0012, 128'h0, QA, 6};
    vecs[8] = '{1'b1, 16'hFFFF, QC, QA, 5};
    vecs[9] = '{1'b0, 16'hFFFF, 128'h0, QC, 6};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      bus_addr[d] = '0; bus_data[d] = '0; bus_valid[d] = 1'b0; bus_we[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ack", ack[d], 0);
      check("rst_rdata", rdata_o[d], 0);
      check("rst_en", mem_en[d], 0);
      check("rst_we", mem_we[d], 0);
    end
    rst_n = 1'b1;
    last_rd = '0;

    // Directed vectors on the zero-wait instance.
    for (int i = 0; i < 10; i++) begin
      run_txn(0, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp_rdata,
              vecs[i].exp_lat, 0, 1'b0);
      if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].data;
      else last_rd = vecs[i].exp_rdata;
    end

    // Request held high for two cycles after the ack, then a fresh request.
    txn0(1'b0, 16'h0012, 128'h0, 2, 1'b0);
    txn0(1'b0, 16'h0000, 128'h0, 0, 1'b0);

    // Reset during beat 1 of a read abandons it.
    @(negedge clk);
    bus_addr[0] = 16'h0012; bus_we[0] = 1'b0; bus_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_beat0_en", mem_en[0], 1);
    @(negedge clk);
    check("abort_beat1_addr", mem_addr[0], 18'h00049);
    rst_n = 1'b0;
    bus_valid[0] = 1'b0;
    @(negedge clk);
    check("abort_en", mem_en[0], 0);
    check("abort_ack", ack[0], 0);
    check("abort_rdata", rdata_o[0], 0);
    rst_n = 1'b1;
    last_rd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_idle_ack", ack[0], 0);
      check("abort_idle_en", mem_en[0], 0);
    end
    txn0(1'b0, 16'h0012, 128'h0, 0, 1'b0);

    // Three wait states on the second instance.
    run_txn(1, 1'b1, 16'h0012, QA, 128'h0, 8, 0, 1'b0);
    run_txn(1, 1'b0, 16'h0012, 128'h0, QA, 9, 0, 1'b0);

    // Alternating write/read with the minimum request gap.
    for (int i = 0; i < 3; i++) begin
      txn0(1'b1, 16'h0000, QP, 0, 1'b0);
      txn0(1'b0, 16'h0001, 128'h0, 0, 1'b0);
    end

    // Randomised traffic over a small address window, with mid-transfer
    // input scrambling and random post-ack hold times.
    for (int i = 0; i < 40; i++) begin
      txn0(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)),
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
